// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect write path: width helpers,
// slave-count defaults and the W-channel burst-completion handshake.
package axi_ic_pkg;

   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Width able to hold every value 0..n inclusive.
   function automatic int unsigned cnt_width(input int unsigned n);
      return width_of(n + 1);
   endfunction

   localparam int unsigned SLAVES_NUM_DEF = 4;
   localparam int unsigned ID_SIZE_DEF    = width_of(SLAVES_NUM_DEF);

   typedef struct packed {
      logic wvalid;
      logic wready;
      logic wlast;
   } w_hs_t;

   localparam w_hs_t W_BURST_DONE = '{wvalid: 1'b1, wready: 1'b1, wlast: 1'b1};

   // Forms the queue Pop from the W channel signals.
   function automatic logic w_burst_done(input w_hs_t hs);
      return hs == W_BURST_DONE;
   endfunction

endpackage

// File: rtl/wrap_ptr.sv
// Modulo-Depth pointer with increment enable; wraps by explicit compare so
// non-power-of-2 depths work.
module wrap_ptr
   import axi_ic_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter int unsigned Ptr_W = width_of(Depth)
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             Clear,
   input  logic             Inc,
   output logic [Ptr_W-1:0] Ptr
);

   logic [Ptr_W-1:0] ptr_reg;
   logic [Ptr_W-1:0] ptr_next;

   always_comb begin
      ptr_next = ptr_reg;
      if (Clear) begin
         ptr_next = '0;
      end else if (Inc) begin
         ptr_next = (ptr_reg == Ptr_W'(Depth - 1)) ? '0 : ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

   assign Ptr = ptr_reg;

endmodule

// File: rtl/wr_order_queue.sv
// In-order tracker of granted AW transactions: the head entry selects the
// slave the W channel routes to; a completed W burst pops it.
module wr_order_queue
   import axi_ic_pkg::*;
#(
   parameter int unsigned Slaves_Num = SLAVES_NUM_DEF,
   parameter int unsigned Depth      = 4,
   parameter int unsigned ID_Size    = width_of(Slaves_Num),
   parameter int unsigned Cnt_W      = cnt_width(Depth),
   parameter int unsigned AF_Thr     = Depth - 1
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  Push,
   input  logic [ID_Size-1:0]    Push_Slave_ID,
   input  logic                  Pop,
   input  logic                  Flush,
   output logic                  Head_Valid,
   output logic [ID_Size-1:0]    Head_Slave_ID,
   output logic                  Head_Start_Pulse,
   output logic [Cnt_W-1:0]      Count,
   output logic                  Full,
   output logic                  Almost_Full,
   output logic [Slaves_Num-1:0] Pending_Mask,
   output logic                  Overflow_Err,
   output logic                  Underflow_Err
);

   localparam int unsigned Ptr_W = width_of(Depth);

   logic [ID_Size-1:0] mem_reg [Depth];
   logic [Ptr_W-1:0]   wr_ptr;
   logic [Ptr_W-1:0]   rd_ptr;
   logic [Cnt_W-1:0]   count_reg, count_next;
   logic               start_reg, start_next;
   logic               ovf_reg, ovf_next;
   logic               unf_reg, unf_next;
   logic               empty, full;
   logic               push_ok, pop_ok;
   logic [ID_Size-1:0] head_raw;

   assign empty    = (count_reg == '0);
   assign full     = (count_reg == Cnt_W'(Depth));
   assign head_raw = mem_reg[rd_ptr];

   // A full queue still takes a push when the head leaves in the same cycle.
   assign push_ok = Push && !Flush && (!full || Pop);
   assign pop_ok  = Pop && !Flush && !empty;

   wrap_ptr #(.Depth(Depth), .Ptr_W(Ptr_W)) u_wr_ptr (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .Clear  (Flush),
      .Inc    (push_ok),
      .Ptr    (wr_ptr)
   );

   wrap_ptr #(.Depth(Depth), .Ptr_W(Ptr_W)) u_rd_ptr (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .Clear  (Flush),
      .Inc    (pop_ok),
      .Ptr    (rd_ptr)
   );

   always_ff @(posedge ACLK) begin
      if (push_ok) begin
         mem_reg[wr_ptr] <= Push_Slave_ID;
      end
   end

   always_comb begin
      count_next = count_reg;
      start_next = 1'b0;
      ovf_next   = ovf_reg;
      unf_next   = unf_reg;
      if (Flush) begin
         count_next = '0;
      end else begin
         if (push_ok && !pop_ok) begin
            count_next = count_reg + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count_next = count_reg - 1'b1;
         end
         // A new entry reaches the head at this edge.
         start_next = (push_ok && empty)
                    || (pop_ok && (count_reg >= Cnt_W'(2)))
                    || (push_ok && pop_ok && (count_reg == Cnt_W'(1)));
         if (Push && !push_ok) begin
            ovf_next = 1'b1;
         end
         if (Pop && empty) begin
            unf_next = 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         count_reg <= '0;
         start_reg <= 1'b0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
      end else begin
         count_reg <= count_next;
         start_reg <= start_next;
         ovf_reg   <= ovf_next;
         unf_reg   <= unf_next;
      end
   end

   // Out-of-range IDs never match any counter, so they leave the mask alone.
   for (genvar gi = 0; gi < Slaves_Num; gi++) begin : g_slave
      logic [Cnt_W-1:0] slv_cnt_reg;
      logic [Cnt_W-1:0] slv_cnt_next;
      logic             inc;
      logic             dec;

      assign inc = push_ok && (Push_Slave_ID == ID_Size'(gi));
      assign dec = pop_ok && (head_raw == ID_Size'(gi));

      always_comb begin
         slv_cnt_next = slv_cnt_reg;
         if (Flush) begin
            slv_cnt_next = '0;
         end else if (inc && !dec) begin
            slv_cnt_next = slv_cnt_reg + 1'b1;
         end else if (dec && !inc) begin
            slv_cnt_next = slv_cnt_reg - 1'b1;
         end
      end

      always_ff @(posedge ACLK) begin
         if (ARESET) begin
            slv_cnt_reg <= '0;
         end else begin
            slv_cnt_reg <= slv_cnt_next;
         end
      end

      assign Pending_Mask[gi] = (slv_cnt_reg != '0);
   end

   assign Head_Valid       = !empty;
   assign Head_Slave_ID    = empty ? '0 : head_raw;
   assign Head_Start_Pulse = start_reg;
   assign Count            = count_reg;
   assign Full             = full;
   assign Almost_Full      = (count_reg >= Cnt_W'(AF_Thr));
   assign Overflow_Err     = ovf_reg;
   assign Underflow_Err    = unf_reg;

endmodule

// File: tb/tb_wr_order_queue.sv
// Directed table-driven check of wr_order_queue (Depth=3, Slaves_Num=4) plus
// a randomised wrap-around sequence against a FIFO scoreboard.
module tb_wr_order_queue;

   localparam int unsigned SN = 4;
   localparam int unsigned DP = 3;

   logic       ACLK;
   logic       ARESET;
   logic       Push;
   logic [1:0] Push_Slave_ID;
   logic       Pop;
   logic       Flush;
   logic       Head_Valid;
   logic [1:0] Head_Slave_ID;
   logic       Head_Start_Pulse;
   logic [1:0] Count;
   logic       Full;
   logic       Almost_Full;
   logic [3:0] Pending_Mask;
   logic       Overflow_Err;
   logic       Underflow_Err;

   int n_cmp;
   int n_err;

   wr_order_queue #(.Slaves_Num(SN), .Depth(DP)) dut (
      .ACLK             (ACLK),
      .ARESET           (ARESET),
      .Push             (Push),
      .Push_Slave_ID    (Push_Slave_ID),
      .Pop              (Pop),
      .Flush            (Flush),
      .Head_Valid       (Head_Valid),
      .Head_Slave_ID    (Head_Slave_ID),
      .Head_Start_Pulse (Head_Start_Pulse),
      .Count            (Count),
      .Full             (Full),
      .Almost_Full      (Almost_Full),
      .Pending_Mask     (Pending_Mask),
      .Overflow_Err     (Overflow_Err),
      .Underflow_Err    (Underflow_Err)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef struct {
      logic       push;
      logic [1:0] id;
      logic       pop;
      logic       flush;
      logic [1:0] cnt;
      logic       hv;
      logic [1:0] hid;
      logic       sp;
      logic       full;
      logic       af;
      logic [3:0] mask;
      logic       ovf;
      logic       unf;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic push, input logic [1:0] id, input logic pop,
                               input logic flush, input logic [1:0] cnt, input logic hv,
                               input logic [1:0] hid, input logic sp, input logic full,
                               input logic af, input logic [3:0] mask, input logic ovf,
                               input logic unf);
      vec_t v;
      v.push = push; v.id = id; v.pop = pop; v.flush = flush;
      v.cnt = cnt; v.hv = hv; v.hid = hid; v.sp = sp; v.full = full;
      v.af = af; v.mask = mask; v.ovf = ovf; v.unf = unf;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL step %0d %s: got %0h, expected %0h", idx, name, act, exp);
      end
   endtask

   task automatic drive(input logic push, input logic [1:0] id, input logic pop,
                        input logic flush);
      Push = push; Push_Slave_ID = id; Pop = pop; Flush = flush;
      @(posedge ACLK);
      #1;
      Push = 1'b0; Pop = 1'b0; Flush = 1'b0;
   endtask

   task automatic do_reset(input int tag);
      ARESET = 1'b1; Push = 1'b1; Push_Slave_ID = 2'd2; Pop = 1'b0; Flush = 1'b0;
      repeat (2) @(posedge ACLK);
      #1;
      chk("rst_count", tag, 32'(Count), 32'd0);
      chk("rst_head_valid", tag, 32'(Head_Valid), 32'd0);
      chk("rst_pending", tag, 32'(Pending_Mask), 32'd0);
      chk("rst_ovf", tag, 32'(Overflow_Err), 32'd0);
      chk("rst_unf", tag, 32'(Underflow_Err), 32'd0);
      chk("rst_start", tag, 32'(Head_Start_Pulse), 32'd0);
      ARESET = 1'b0; Push = 1'b0;
   endtask

   initial begin
      int   q[$];
      logic p, o;
      logic [1:0] id;
      logic pa, oa;

      n_cmp = 0;
      n_err = 0;
      ARESET = 1'b1; Push = 1'b0; Push_Slave_ID = '0; Pop = 1'b0; Flush = 1'b0;

      //            push id   pop flush cnt hv hid sp full af mask     ovf unf
      vecs[0]  = mk(1, 2'd2, 0, 0, 2'd1, 1, 2'd2, 1, 0, 0, 4'b0100, 0, 0);
      vecs[1]  = mk(1, 2'd0, 0, 0, 2'd2, 1, 2'd2, 0, 0, 1, 4'b0101, 0, 0);
      vecs[2]  = mk(1, 2'd3, 0, 0, 2'd3, 1, 2'd2, 0, 1, 1, 4'b1101, 0, 0);
      vecs[3]  = mk(0, 2'd0, 1, 0, 2'd2, 1, 2'd0, 1, 0, 1, 4'b1001, 0, 0);
      vecs[4]  = mk(0, 2'd0, 1, 0, 2'd1, 1, 2'd3, 1, 0, 0, 4'b1000, 0, 0);
      vecs[5]  = mk(0, 2'd0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0, 4'b0000, 0, 0);
      vecs[6]  = mk(0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 4'b0000, 0, 0);
      // back-to-back heads with the same slave
      vecs[7]  = mk(1, 2'd1, 0, 0, 2'd1, 1, 2'd1, 1, 0, 0, 4'b0010, 0, 0);
      vecs[8]  = mk(1, 2'd1, 0, 0, 2'd2, 1, 2'd1, 0, 0, 1, 4'b0010, 0, 0);
      vecs[9]  = mk(0, 2'd0, 1, 0, 2'd1, 1, 2'd1, 1, 0, 0, 4'b0010, 0, 0);
      vecs[10] = mk(0, 2'd0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0, 4'b0000, 0, 0);
      // fill, then push+pop while full, then push while full
      vecs[11] = mk(1, 2'd0, 0, 0, 2'd1, 1, 2'd0, 1, 0, 0, 4'b0001, 0, 0);
      vecs[12] = mk(1, 2'd1, 0, 0, 2'd2, 1, 2'd0, 0, 0, 1, 4'b0011, 0, 0);
      vecs[13] = mk(1, 2'd2, 0, 0, 2'd3, 1, 2'd0, 0, 1, 1, 4'b0111, 0, 0);
      vecs[14] = mk(1, 2'd3, 1, 0, 2'd3, 1, 2'd1, 1, 1, 1, 4'b1110, 0, 0);
      vecs[15] = mk(1, 2'd0, 0, 0, 2'd3, 1, 2'd1, 0, 1, 1, 4'b1110, 1, 0);
      vecs[16] = mk(0, 2'd0, 1, 0, 2'd2, 1, 2'd2, 1, 0, 1, 4'b1100, 1, 0);
      vecs[17] = mk(0, 2'd0, 1, 0, 2'd1, 1, 2'd3, 1, 0, 0, 4'b1000, 1, 0);
      vecs[18] = mk(0, 2'd0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0, 4'b0000, 1, 0);
      // underflow, push+pop on empty, flush keeps errors
      vecs[19] = mk(0, 2'd0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0, 4'b0000, 1, 1);
      vecs[20] = mk(1, 2'd1, 1, 0, 2'd1, 1, 2'd1, 1, 0, 0, 4'b0010, 1, 1);
      vecs[21] = mk(1, 2'd2, 0, 0, 2'd2, 1, 2'd1, 0, 0, 1, 4'b0110, 1, 1);
      vecs[22] = mk(0, 2'd0, 0, 1, 2'd0, 0, 2'd0, 0, 0, 0, 4'b0000, 1, 1);
      vecs[23] = mk(1, 2'd2, 0, 1, 2'd0, 0, 2'd0, 0, 0, 0, 4'b0000, 1, 1);
      // push+pop with one entry: pushed entry becomes head
      vecs[24] = mk(1, 2'd3, 0, 0, 2'd1, 1, 2'd3, 1, 0, 0, 4'b1000, 1, 1);
      vecs[25] = mk(1, 2'd0, 1, 0, 2'd1, 1, 2'd0, 1, 0, 0, 4'b0001, 1, 1);
      vecs[26] = mk(0, 2'd0, 0, 0, 2'd1, 1, 2'd0, 0, 0, 0, 4'b0001, 1, 1);
      vecs[27] = mk(0, 2'd0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0, 4'b0000, 1, 1);

      do_reset(-1);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].push, vecs[i].id, vecs[i].pop, vecs[i].flush);
         $display("vec %0d: push=%0b id=%0d pop=%0b flush=%0b -> count=%0d hv=%0b head=%0d sp=%0b mask=%b ovf=%0b unf=%0b",
                  i, vecs[i].push, vecs[i].id, vecs[i].pop, vecs[i].flush, Count, Head_Valid,
                  Head_Slave_ID, Head_Start_Pulse, Pending_Mask, Overflow_Err, Underflow_Err);
         chk("count", i, 32'(Count), 32'(vecs[i].cnt));
         chk("head_valid", i, 32'(Head_Valid), 32'(vecs[i].hv));
         chk("head_id", i, 32'(Head_Slave_ID), 32'(vecs[i].hid));
         chk("start_pulse", i, 32'(Head_Start_Pulse), 32'(vecs[i].sp));
         chk("full", i, 32'(Full), 32'(vecs[i].full));
         chk("almost_full", i, 32'(Almost_Full), 32'(vecs[i].af));
         chk("pending", i, 32'(Pending_Mask), 32'(vecs[i].mask));
         chk("overflow", i, 32'(Overflow_Err), 32'(vecs[i].ovf));
         chk("underflow", i, 32'(Underflow_Err), 32'(vecs[i].unf));
      end

      // Wrap-around with random traffic against a FIFO scoreboard.
      do_reset(-2);
      q.delete();
      for (int i = 0; i < 40; i++) begin
         p  = 1'($urandom_range(0, 1));
         o  = 1'($urandom_range(0, 1));
         id = 2'($urandom_range(0, 3));
         oa = o && (q.size() > 0);
         pa = p && ((q.size() < DP) || oa);
         if (oa) void'(q.pop_front());
         if (pa) q.push_back(int'(id));
         drive(p, id, o, 1'b0);
         $display("wrap %0d: push=%0b id=%0d pop=%0b -> count=%0d head=%0d exp_size=%0d",
                  i, p, id, o, Count, Head_Slave_ID, q.size());
         chk("wrap_count", 100 + i, 32'(Count), 32'(q.size()));
         chk("wrap_le_depth", 100 + i, 32'(Count <= 2'(DP)), 32'd1);
         if (q.size() > 0) begin
            chk("wrap_head", 100 + i, 32'(Head_Slave_ID), 32'(q[0]));
         end
      end

      do_reset(-3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
